// File: rtl/debug_slave_pkg.sv
// Shared types and constants for the system-clock side of the JTAG debug slave.
package debug_slave_pkg;

  localparam int unsigned DEFAULT_DR_WIDTH    = 38;
  localparam int unsigned DEFAULT_IR_WIDTH    = 2;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
  localparam int unsigned DEFAULT_FIFO_DEPTH  = 4;

  // Command as captured at the default widths.
  typedef struct packed {
    logic [DEFAULT_IR_WIDTH-1:0] ir;
    logic [DEFAULT_DR_WIDTH-1:0] data;
  } cmd_t;

  // Virtual IR channel opcodes.
  localparam logic [DEFAULT_IR_WIDTH-1:0] OP_OCIMEM  = 2'd0;
  localparam logic [DEFAULT_IR_WIDTH-1:0] OP_BREAK_A = 2'd1;
  localparam logic [DEFAULT_IR_WIDTH-1:0] OP_BREAK_B = 2'd2;
  localparam logic [DEFAULT_IR_WIDTH-1:0] OP_BREAK_C = 2'd3;

  // MSB of the scan register is the "take action" flag.
  function automatic int unsigned action_bit(input int unsigned dr_width);
    return dr_width - 1;
  endfunction

endpackage

// File: rtl/debug_sync_edge.sv
// Multi-flop synchroniser with an armed rising-edge detector.
module debug_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse_c
);

  logic [SYNC_STAGES-1:0] chain;
  logic [SYNC_STAGES-1:0] fill;
  logic                   prev;
  logic                   armed;
  logic                   sync_out;

  assign sync_out = chain[SYNC_STAGES-1];

  // fill tracks when sync_out reflects a real post-reset sample, so a strobe
  // held high through reset is never mistaken for a fresh low-to-high edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      fill  <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
      prev  <= sync_out;
      if (fill[SYNC_STAGES-1] && !sync_out) armed <= 1'b1;
    end
  end

  assign pulse_c = sync_out & ~prev & armed;

endmodule

// File: rtl/debug_slave_cmd_sync.sv
// Synchronises TAP update strobes and queues one scan command per update-DR.
module debug_slave_cmd_sync
  import debug_slave_pkg::*;
#(
  parameter int unsigned DR_WIDTH    = DEFAULT_DR_WIDTH,
  parameter int unsigned IR_WIDTH    = DEFAULT_IR_WIDTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic [DR_WIDTH-1:0]           sr,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [IR_WIDTH-1:0]           cmd_ir,
  output logic [DR_WIDTH-1:0]           cmd_data,
  output logic [(2**IR_WIDTH)-1:0]      cmd_sel,
  output logic                          cmd_action,
  output logic                          cmd_no_action,
  output logic                          ir_update,
  output logic [IR_WIDTH-1:0]           ir_current,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned SEL_W = 2**IR_WIDTH;
  localparam int unsigned ACT   = action_bit(DR_WIDTH);

  typedef struct packed {
    logic [IR_WIDTH-1:0] ir;
    logic [DR_WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            udr_pulse;
  logic            uir_pulse;
  logic            empty;
  logic            full;
  logic            pop;
  logic            wr_en;
  logic            drop;

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(vs_udr),
    .pulse_c (udr_pulse)
  );

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(vs_uir),
    .pulse_c (uir_pulse)
  );

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & cmd_ready;
  assign wr_en = udr_pulse & (~full | pop);
  assign drop  = udr_pulse & full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      ir_update  <= 1'b0;
      ir_current <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
      ir_update <= uir_pulse;
      if (uir_pulse) ir_current <= ir_in;
    end
  end

  // Storage needs no reset: every read is qualified by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= '{ir: ir_in, data: sr};
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign cmd_valid     = ~empty;
  assign cmd_ir        = cmd_valid ? head.ir : '0;
  assign cmd_data      = cmd_valid ? head.data : '0;
  assign cmd_sel       = cmd_valid ? (SEL_W'(1) << head.ir) : '0;
  assign cmd_action    = cmd_valid & head.data[ACT];
  assign cmd_no_action = cmd_valid & ~head.data[ACT];
  assign fifo_level    = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_debug_slave_cmd_sync.sv
// Directed bench for debug_slave_cmd_sync with a queue-based reference model.
module tb_debug_slave_cmd_sync;

  localparam int unsigned DRW   = 38;
  localparam int unsigned IRW   = 2;
  localparam int unsigned S     = 2;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            vs_udr, vs_uir;
  logic [IRW-1:0]  ir_in;
  logic [DRW-1:0]  sr;
  logic            cmd_valid, cmd_ready;
  logic [IRW-1:0]  cmd_ir;
  logic [DRW-1:0]  cmd_data;
  logic [3:0]      cmd_sel;
  logic            cmd_action, cmd_no_action;
  logic            ir_update;
  logic [IRW-1:0]  ir_current;
  logic [2:0]      fifo_level;
  logic            overflow, overflow_clr;

  int checks = 0;
  int errors = 0;

  debug_slave_cmd_sync dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_sel(cmd_sel),
    .cmd_action(cmd_action), .cmd_no_action(cmd_no_action),
    .ir_update(ir_update), .ir_current(ir_current), .fifo_level(fifo_level),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a strobe sample seen at edge e-S that is high after a real
  // post-reset low sample produces a push at edge e.
  typedef struct { logic [IRW-1:0] ir; logic [DRW-1:0] data; } ent_t;
  ent_t           mq[$];
  bit             udr_h[$];
  bit             uir_h[$];
  bit             m_ovf;
  bit             m_irupd;
  logic [IRW-1:0] m_ircur;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete(); udr_h.delete(); uir_h.delete();
      m_ovf = 0; m_irupd = 0; m_ircur = '0;
    end else begin
      bit pu, pi, pop, drop;
      int n;
      udr_h.push_back(vs_udr);
      uir_h.push_back(vs_uir);
      n = udr_h.size();
      pu = (n >= int'(S) + 2) && udr_h[n-1-S] && !udr_h[n-2-S];
      pi = (n >= int'(S) + 2) && uir_h[n-1-S] && !uir_h[n-2-S];
      pop  = (mq.size() > 0) && cmd_ready;
      drop = pu && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (pu && !drop) mq.push_back('{ir: ir_in, data: sr});
      if (drop) m_ovf = 1;
      else if (overflow_clr) m_ovf = 0;
      m_irupd = pi;
      if (pi) m_ircur = ir_in;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [DRW-1:0] ed;
    logic [IRW-1:0] ei;
    bit v;
    v  = mq.size() > 0;
    ed = v ? mq[0].data : '0;
    ei = v ? mq[0].ir : '0;
    check("cyc_valid", 64'(cmd_valid), 64'(v));
    check("cyc_data", 64'(cmd_data), 64'(ed));
    check("cyc_ir", 64'(cmd_ir), 64'(ei));
    check("cyc_sel", 64'(cmd_sel), v ? 64'(4'b1 << ei) : 64'd0);
    check("cyc_action", 64'(cmd_action), 64'(v && ed[DRW-1]));
    check("cyc_no_action", 64'(cmd_no_action), 64'(v && !ed[DRW-1]));
    check("cyc_level", 64'(fifo_level), 64'(mq.size()));
    check("cyc_overflow", 64'(overflow), 64'(m_ovf));
    check("cyc_ir_update", 64'(ir_update), 64'(m_irupd));
    check("cyc_ir_current", 64'(ir_current), 64'(m_ircur));
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic udr_pulse(input logic [IRW-1:0] ir, input logic [DRW-1:0] d);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    tick(4);
    vs_udr = 1'b0;
    tick(4);
  endtask

  logic [DRW-1:0] vals [6];
  logic [DRW-1:0] exp4 [4];

  initial begin
    bit found;
    reset = 1'b1; vs_udr = 1'b1; vs_uir = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; overflow_clr = 1'b0;
    for (int i = 0; i < 6; i++) vals[i] = DRW'(38'h00_1111_0000 + 38'(i));
    tick(3);
    check("reset_valid", 64'(cmd_valid), 64'd0);
    check("reset_level", 64'(fifo_level), 64'd0);
    check("reset_ir_current", 64'(ir_current), 64'd0);

    // 1: strobe high across reset release produces nothing
    reset = 1'b0;
    tick(10);
    check("t1_held_high_no_cmd", 64'(cmd_valid), 64'd0);
    vs_udr = 1'b0;
    tick(4);
    ir_in = 2'd0; sr = 38'h00_0000_0055; vs_udr = 1'b1;
    tick(1); check("t1_edge1", 64'(cmd_valid), 64'd0);
    tick(1); check("t1_edge2", 64'(cmd_valid), 64'd0);
    tick(1); check("t1_edge3", 64'(cmd_valid), 64'd1);
    check("t1_data", 64'(cmd_data), 64'h55);
    vs_udr = 1'b0; cmd_ready = 1'b1;
    tick(1); cmd_ready = 1'b0;
    tick(4);

    // 2: single action command, consumed immediately
    cmd_ready = 1'b1;
    ir_in = 2'b01; sr = 38'h20_0000_00AB; vs_udr = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      found = cmd_valid;
    end
    check("t2_wait_valid", 64'(found), 64'd1);
    check("t2_sel", 64'(cmd_sel), 64'b0010);
    check("t2_action", 64'(cmd_action), 64'd1);
    check("t2_data", 64'(cmd_data), 64'h20_0000_00AB);
    tick(1);
    check("t2_one_cycle", 64'(cmd_valid), 64'd0);
    vs_udr = 1'b0; tick(4); cmd_ready = 1'b0;

    // 3: overflow with six pulses, drain first four in order
    for (int i = 0; i < 6; i++) udr_pulse(2'd2, vals[i]);
    check("t3_level", 64'(fifo_level), 64'd4);
    check("t3_overflow", 64'(overflow), 64'd1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain", 64'(cmd_data), 64'(vals[i]));
      tick(1);
    end
    cmd_ready = 1'b0;
    check("t3_empty", 64'(cmd_valid), 64'd0);
    overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
    check("t3_ovf_cleared", 64'(overflow), 64'd0);

    // 4: push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) udr_pulse(2'd3, vals[i] ^ 38'h3F_0000_0000);
    ir_in = 2'd2; sr = 38'h00_00EE_EEEE; vs_udr = 1'b1;
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("t4_level", 64'(fifo_level), 64'd4);
    check("t4_overflow", 64'(overflow), 64'd0);
    vs_udr = 1'b0; tick(4);
    for (int i = 0; i < 3; i++) exp4[i] = vals[i+1] ^ 38'h3F_0000_0000;
    exp4[3] = 38'h00_00EE_EEEE;
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain", 64'(cmd_data), 64'(exp4[i]));
      tick(1);
    end
    cmd_ready = 1'b0;

    // 5: update-IR pulse, then clear racing a drop
    ir_in = 2'b11; vs_uir = 1'b1;
    tick(1); check("t5_uir_e1", 64'(ir_update), 64'd0);
    tick(1); check("t5_uir_e2", 64'(ir_update), 64'd0);
    tick(1); check("t5_uir_e3", 64'(ir_update), 64'd1);
    check("t5_ir_current", 64'(ir_current), 64'd3);
    tick(1); check("t5_uir_once", 64'(ir_update), 64'd0);
    vs_uir = 1'b0; tick(4);
    for (int i = 0; i < 4; i++) udr_pulse(2'd0, vals[i]);
    ir_in = 2'd1; sr = 38'h00_0000_0099; vs_udr = 1'b1;
    tick(2);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("t5_set_wins", 64'(overflow), 64'd1);
    check("t5_level", 64'(fifo_level), 64'd4);
    vs_udr = 1'b0; tick(4);
    overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
    check("t5_clr", 64'(overflow), 64'd0);

    // 6: reset discards queued commands immediately
    cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;
    check("t6_level3", 64'(fifo_level), 64'd3);
    reset = 1'b1;
    #1;
    check("t6_valid_now", 64'(cmd_valid), 64'd0);
    check("t6_level_now", 64'(fifo_level), 64'd0);
    tick(2);
    reset = 1'b0;
    tick(10);
    check("t6_no_stale", 64'(cmd_valid), 64'd0);
    check("t6_level_after", 64'(fifo_level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
